// File: rtl/mux8_1_reg.sv
// Eight-way WIDTH-bit selector with a registered output, built as a tree of
// 2:1 cells: two 4:1 stages on {s1,s0} followed by a final 2:1 stage on s2.

module mux2_cell #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    // The conditional operator passes only the selected word, so an
    // unknown value on the other leg cannot leak through.
    assign y = sel ? b : a;

endmodule

module mux4_cell #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             s0,
    input  logic             s1,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] ab;
    logic [WIDTH-1:0] cd;

    mux2_cell #(.WIDTH(WIDTH)) u_ab (.a(a),  .b(b),  .sel(s0), .y(ab));
    mux2_cell #(.WIDTH(WIDTH)) u_cd (.a(c),  .b(d),  .sel(s0), .y(cd));
    mux2_cell #(.WIDTH(WIDTH)) u_y  (.a(ab), .b(cd), .sel(s1), .y(y));

endmodule

module mux8_1_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] h,
    input  logic             s0,
    input  logic             s1,
    input  logic             s2,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] next_y;

    mux4_cell #(.WIDTH(WIDTH)) u_lo (
        .a(a), .b(b), .c(c), .d(d), .s0(s0), .s1(s1), .y(lo)
    );

    mux4_cell #(.WIDTH(WIDTH)) u_hi (
        .a(e), .b(f), .c(g), .d(h), .s0(s0), .s1(s1), .y(hi)
    );

    mux2_cell #(.WIDTH(WIDTH)) u_final (
        .a(lo), .b(hi), .sel(s2), .y(next_y)
    );

    // Reset wins over capture so a mid-stream pulse clears y on that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            y <= '0;
        end else begin
            y <= next_y;
        end
    end

endmodule

// File: tb/tb_mux8_1_reg.sv
// Self-checking bench for mux8_1_reg: directed scenarios plus random traffic,
// each cycle compared with an array-indexed reference of the selected word.

module tb_mux8_1_reg;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] words [8];
    logic             s0;
    logic             s1;
    logic             s2;
    logic [WIDTH-1:0] y;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux8_1_reg #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .a(words[0]),
        .b(words[1]),
        .c(words[2]),
        .d(words[3]),
        .e(words[4]),
        .f(words[5]),
        .g(words[6]),
        .h(words[7]),
        .s0(s0),
        .s1(s1),
        .s2(s2),
        .y(y)
    );

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: y=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic setSel(input int sel);
        {s2, s1, s0} = sel[2:0];
    endtask

    task automatic randomizeAll();
        for (int i = 0; i < 8; i++) words[i] = WIDTH'($urandom);
        setSel(int'($urandom_range(0, 7)));
    endtask

    // Reference: the word picked by the select index one edge ago, or zero under reset.
    task automatic applyStimulus(input string tag);
        logic [WIDTH-1:0] expected;
        int sel;
        sel = {29'd0, s2, s1, s0};
        expected = rst ? '0 : words[sel];
        @(posedge clk);
        #1;
        checkOutput(tag, y, expected);
    endtask

    initial begin
        // Reset with every input at all-ones and the top index selected.
        rst = 1'b1;
        for (int i = 0; i < 8; i++) words[i] = 8'hFF;
        setSel(7);
        applyStimulus("reset0");
        applyStimulus("reset1");
        rst = 1'b0;
        applyStimulus("reset_release");

        // Sweep every index once with distinct words.
        for (int i = 0; i < 8; i++) words[i] = 8'(8'h11 * (i + 1));
        for (int sel = 0; sel < 8; sel++) begin
            setSel(sel);
            applyStimulus($sformatf("sweep%0d", sel));
        end

        // Unselected inputs churn while index 5 holds a fixed word.
        setSel(5);
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < 8; i++) words[i] = WIDTH'($urandom);
            words[5] = 8'hA5;
            applyStimulus("isolation");
        end

        // MSB transition from index 3 to index 7.
        words[3] = 8'h0F;
        words[7] = 8'hF0;
        setSel(3);
        applyStimulus("msb_lo");
        setSel(7);
        applyStimulus("msb_hi");

        // Random traffic interrupted by a single-cycle reset pulse.
        for (int n = 0; n < 20; n++) begin
            randomizeAll();
            applyStimulus("pre_pulse");
        end
        randomizeAll();
        rst = 1'b1;
        applyStimulus("mid_reset");
        rst = 1'b0;
        randomizeAll();
        applyStimulus("post_reset");

        // Long random run, occasionally pulsing reset.
        for (int n = 0; n < 1000; n++) begin
            randomizeAll();
            rst = ($urandom_range(0, 49) == 0);
            applyStimulus("random");
        end
        rst = 1'b0;
        randomizeAll();
        applyStimulus("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
